// File: rtl/br_update_pkg.sv
// Types and helpers shared by the branch update queue and the branch predictor.
package br_update_pkg;

  localparam int HIST_W_DFLT = 5;
  localparam int CNT_W_DFLT  = 2;
  localparam int IDX_W_DFLT  = 2 * HIST_W_DFLT;

  typedef enum logic {INIT, RUN} updState_t;

  typedef struct packed {
    logic [IDX_W_DFLT-1:0] idx;
    logic [CNT_W_DFLT-1:0] cnt;
    logic                  taken;
  } brEntry_t;

  // PHT index: local history in the upper half, word-aligned PC bits below.
  function automatic logic [IDX_W_DFLT-1:0] phtIndex(input logic [HIST_W_DFLT-1:0] hist,
                                                     input logic [HIST_W_DFLT-1:0] pcBits);
    return {hist, pcBits};
  endfunction

endpackage

// File: rtl/br_update_fifo.sv
// Circular buffer with compacted multi-entry push and peek/pop of the oldest
// PORTS entries; depth must be a power of two so pointers wrap for free.
module br_update_fifo
  import br_update_pkg::*;
#(
  parameter int W     = IDX_W_DFLT + CNT_W_DFLT + 1,
  parameter int DEPTH = 8,
  parameter int PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           pushValid,
  input  logic [W-1:0]               pushData [PORTS],
  input  logic [$clog2(DEPTH+1)-1:0] popCnt,
  output logic [W-1:0]               peekData [PORTS],
  output logic [PORTS-1:0]           peekValid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] pushCnt;

  always_comb begin
    pushCnt = '0;
    for (int i = 0; i < PORTS; i++) pushCnt = pushCnt + CW'(pushValid[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      headPtr <= headPtr + PW'(popCnt);
      tailPtr <= tailPtr + PW'(pushCnt);
      count   <= count + pushCnt - popCnt;
    end
  end

  // Push ports are a valid prefix, so port i lands at tail+i.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (pushValid[i]) mem[tailPtr + PW'(i)] <= pushData[i];
    end
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      peekData[i]  = mem[headPtr + PW'(i)];
      peekValid[i] = (count > CW'(i));
    end
  end

endmodule

// File: rtl/br_update_queue.sv
// Buffers resolved branches and drains them into a two-bank PHT, merging
// same-index pairs; initialises every PHT entry after reset.
//  state | meaning
//  INIT  | walking all PHT indices, writing the weakly-taken counter value
//  RUN   | draining queued updates, up to two PHT writes per cycle
module br_update_queue
  import br_update_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int HIST_W = HIST_W_DFLT,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    resValid,
  input  logic [31:0]         resAddr     [LANES],
  input  logic [CNT_W-1:0]    resPrevCnt  [LANES],
  input  logic [HIST_W-1:0]   resPrevHist [LANES],
  input  logic [LANES-1:0]    resTaken,
  input  logic [LANES-1:0]    resMispred,
  input  logic [LANES-1:0]    resIsCondBr,
  output logic                resReady,
  output logic [LANES-1:0]    phtWE,
  output logic [2*HIST_W-1:0] phtWA       [LANES],
  output logic [CNT_W-1:0]    phtWV       [LANES],
  output logic                recValid,
  output logic [HIST_W-1:0]   recIdx,
  output logic [HIST_W-1:0]   recHist,
  output logic                initBusy
);

  localparam int IDX_W = 2 * HIST_W;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(1) << (CNT_W-1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             taken;
  } qEntry_t;

  localparam int EW = $bits(qEntry_t);

  function automatic logic [CNT_W-1:0] satStep(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (c == '1) ? c : c + CNT_W'(1);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  updState_t        state, stateNxt;
  logic [IDX_W-1:0] initIdx, initIdxNxt;

  qEntry_t          laneEntry [LANES];
  logic [LANES-1:0] pushValid;
  logic [EW-1:0]    pushData  [LANES];
  logic [EW-1:0]    peekData  [LANES];
  logic [LANES-1:0] peekValid;
  logic [CW-1:0]    popCnt;
  logic [CW-1:0]    count;
  qEntry_t          head, nxt;
  logic             unusedBits;

  assign resReady = !rst && (state == RUN) && (count <= CW'(DEPTH - LANES));
  assign initBusy = (state == INIT);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      laneEntry[i].idx   = {resPrevHist[i], resAddr[i][HIST_W+1:2]};
      laneEntry[i].cnt   = satStep(resPrevCnt[i], resTaken[i]);
      laneEntry[i].taken = resTaken[i];
    end
  end

  // Compact accepted lanes onto the lowest push ports, preserving lane order.
  always_comb begin
    int nEn;
    nEn       = 0;
    pushValid = '0;
    for (int j = 0; j < LANES; j++) pushData[j] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (resValid[i] && resReady) begin
        for (int j = 0; j < LANES; j++) begin
          if (j == nEn) begin
            pushValid[j] = 1'b1;
            pushData[j]  = laneEntry[i];
          end
        end
        nEn++;
      end
    end
  end

  br_update_fifo #(.W(EW), .DEPTH(DEPTH), .PORTS(LANES)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .pushValid(pushValid),
    .pushData (pushData),
    .popCnt   (popCnt),
    .peekData (peekData),
    .peekValid(peekValid),
    .count    (count)
  );

  assign head = peekData[0];
  assign nxt  = peekData[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      initIdx <= '0;
    end else begin
      state   <= stateNxt;
      initIdx <= initIdxNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    initIdxNxt = initIdx;
    popCnt     = '0;
    phtWE      = '0;
    for (int i = 0; i < LANES; i++) begin
      phtWA[i] = '0;
      phtWV[i] = '0;
    end
    if (!rst) begin
      case (state)
        INIT: begin
          phtWE[0]   = 1'b1;
          phtWA[0]   = initIdx;
          phtWV[0]   = INIT_CNT;
          initIdxNxt = initIdx + IDX_W'(1);
          if (initIdx == '1) stateNxt = RUN;
        end
        RUN: begin
          if (peekValid[0]) begin
            phtWE[0] = 1'b1;
            phtWA[0] = head.idx;
            phtWV[0] = head.cnt;
            popCnt   = CW'(1);
            if (peekValid[1]) begin
              // Same index folds into one write; same bank otherwise waits a cycle.
              if (nxt.idx == head.idx) begin
                phtWV[0] = satStep(head.cnt, nxt.taken);
                popCnt   = CW'(2);
              end else if (nxt.idx[0] != head.idx[0]) begin
                phtWE[1] = 1'b1;
                phtWA[1] = nxt.idx;
                phtWV[1] = nxt.cnt;
                popCnt   = CW'(2);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    recValid = 1'b0;
    recIdx   = '0;
    recHist  = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (!rst && resValid[i] && resMispred[i] && resIsCondBr[i]) begin
        recValid = 1'b1;
        recIdx   = resAddr[i][HIST_W+1:2];
        recHist  = {resPrevHist[i][HIST_W-2:0], resTaken[i]};
      end
    end
  end

  always_comb begin
    unusedBits = head.taken;
    for (int i = 0; i < LANES; i++) begin
      unusedBits = unusedBits ^ (^{resAddr[i][31:HIST_W+2], resAddr[i][1:0]});
    end
  end

  aNoPushWhenNotReady: assert property (@(posedge clk) disable iff (rst)
    !((|resValid) && !resReady));

endmodule

// File: tb/tb_br_update_queue.sv
// Directed bench for br_update_queue: expected PHT writes are queued by the
// stimulus and consumed by an independent write monitor.
module tb_br_update_queue;

  localparam int LANES  = 2;
  localparam int DEPTH  = 8;
  localparam int HIST_W = 5;
  localparam int CNT_W  = 2;
  localparam int IDX_W  = 2 * HIST_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [LANES-1:0]   resValid;
  logic [31:0]        resAddr     [LANES];
  logic [CNT_W-1:0]   resPrevCnt  [LANES];
  logic [HIST_W-1:0]  resPrevHist [LANES];
  logic [LANES-1:0]   resTaken;
  logic [LANES-1:0]   resMispred;
  logic [LANES-1:0]   resIsCondBr;
  logic               resReady;
  logic [LANES-1:0]   phtWE;
  logic [IDX_W-1:0]   phtWA [LANES];
  logic [CNT_W-1:0]   phtWV [LANES];
  logic               recValid;
  logic [HIST_W-1:0]  recIdx;
  logic [HIST_W-1:0]  recHist;
  logic               initBusy;

  br_update_queue #(.LANES(LANES), .DEPTH(DEPTH), .HIST_W(HIST_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .resValid   (resValid),
    .resAddr    (resAddr),
    .resPrevCnt (resPrevCnt),
    .resPrevHist(resPrevHist),
    .resTaken   (resTaken),
    .resMispred (resMispred),
    .resIsCondBr(resIsCondBr),
    .resReady   (resReady),
    .phtWE      (phtWE),
    .phtWA      (phtWA),
    .phtWV      (phtWV),
    .recValid   (recValid),
    .recIdx     (recIdx),
    .recHist    (recHist),
    .initBusy   (initBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int addr;
    int val;
  } expW_t;

  expW_t expQ[$];
  int    passCnt  = 0;
  int    totalCnt = 0;
  int    wrCnt    = 0;

  task automatic check(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic expectWrite(input int port, input int addr, input int val);
    expW_t e;
    e.port = port;
    e.addr = addr;
    e.val  = val;
    expQ.push_back(e);
  endtask

  // PHT write monitor: every observed write must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int p = 0; p < LANES; p++) begin
          if (phtWE[p]) begin
            expW_t e;
            wrCnt++;
            if (expQ.size() == 0) begin
              totalCnt++;
              $display("FAIL unexpected_write: got port %0d addr 0x%0h val %0d, required no write",
                       p, phtWA[p], phtWV[p]);
            end else begin
              e = expQ.pop_front();
              check("pht_port", p, e.port);
              check("pht_addr", int'(phtWA[p]), e.addr);
              check("pht_val", int'(phtWV[p]), e.val);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLanes();
    resValid    = '0;
    resTaken    = '0;
    resMispred  = '0;
    resIsCondBr = '0;
    for (int i = 0; i < LANES; i++) begin
      resAddr[i]     = '0;
      resPrevCnt[i]  = '0;
      resPrevHist[i] = '0;
    end
  endtask

  task automatic setLane(input int l, input logic [31:0] a, input logic [HIST_W-1:0] h,
                         input logic [CNT_W-1:0] c, input logic t, input logic mp, input logic cb);
    resValid[l]    = 1'b1;
    resAddr[l]     = a;
    resPrevHist[l] = h;
    resPrevCnt[l]  = c;
    resTaken[l]    = t;
    resMispred[l]  = mp;
    resIsCondBr[l] = cb;
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    check(name, expQ.size(), 0);
  endtask

  // Releases reset and follows the full PHT initialisation walk.
  task automatic runInit();
    int cyc;
    int w0;
    for (int i = 0; i < 1024; i++) expectWrite(0, i, 2);
    w0  = wrCnt;
    cyc = 0;
    rst = 1'b0;
    while (cyc < 1100) begin
      @(negedge clk);
      if (!initBusy) break;
      cyc++;
    end
    check("init_cycles", cyc, 1024);
    check("init_writes", wrCnt - w0, 1024);
    check("init_busy_fall", initBusy, 0);
    check("ready_after_init", resReady, 1);
    check("init_queue_empty", expQ.size(), 0);
  endtask

  initial begin
    int m;
    int pairs;
    int seenLow;
    int pushN;

    clearLanes();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_phtWE", phtWE, 0);
    check("rst_recValid", recValid, 0);
    check("rst_resReady", resReady, 0);
    check("rst_initBusy", initBusy, 1);

    runInit();

    // Single taken update saturating at 3.
    tick();
    check("idle_ready", resReady, 1);
    setLane(0, 32'h100, 5'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    expectWrite(0, 0, 3);
    #1;
    check("no_same_cycle_write", phtWE[0], 0);
    tick();
    clearLanes();
    #2;
    check("lat_we0", phtWE[0], 1);
    check("lat_wa0", phtWA[0], 0);
    check("lat_wv0", phtWV[0], 3);
    check("lat_we1", phtWE[1], 0);
    drain("drain_single");

    // Same bank, different index: second entry waits one cycle.
    setLane(0, 32'h08, 5'd0, 2'd1, 1'b1, 1'b0, 1'b1);
    setLane(1, 32'h10, 5'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    expectWrite(0, 2, 2);
    expectWrite(0, 4, 1);
    tick();
    clearLanes();
    #2;
    check("conflict_c1_we1", phtWE[1], 0);
    check("conflict_c1_wa0", phtWA[0], 2);
    tick();
    #2;
    check("conflict_c2_we1", phtWE[1], 0);
    check("conflict_c2_wa0", phtWA[0], 4);
    drain("drain_conflict");

    // Different banks: both ports in one cycle.
    setLane(0, 32'h08, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    setLane(1, 32'h14, 5'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    expectWrite(0, 2, 1);
    expectWrite(1, 5, 2);
    tick();
    clearLanes();
    #2;
    check("dual_we", phtWE, 3);
    drain("drain_dual");

    // Same index, both not taken from 1: one merged write of 0.
    setLane(0, 32'h20, 5'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    setLane(1, 32'h20, 5'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    expectWrite(0, 8, 0);
    tick();
    clearLanes();
    drain("drain_merge_dec");

    // Same index, both taken from 1: merged write of 3.
    setLane(0, 32'h24, 5'd3, 2'd1, 1'b1, 1'b0, 1'b1);
    setLane(1, 32'h24, 5'd3, 2'd1, 1'b1, 1'b0, 1'b1);
    expectWrite(0, 'h69, 3);
    tick();
    clearLanes();
    drain("drain_merge_inc");

    // Lane-1-only mispredict recovery.
    setLane(1, 32'h1C, 5'b10110, 2'd0, 1'b1, 1'b1, 1'b1);
    expectWrite(0, 'h2C7, 1);
    #1;
    check("rec1_valid", recValid, 1);
    check("rec1_idx", recIdx, 7);
    check("rec1_hist", recHist, 5'b01101);
    tick();
    clearLanes();
    drain("drain_rec1");

    // Both lanes mispredict: lane 0 wins.
    setLane(0, 32'h08, 5'b00001, 2'd2, 1'b0, 1'b1, 1'b1);
    setLane(1, 32'h1C, 5'b10110, 2'd3, 1'b1, 1'b1, 1'b1);
    expectWrite(0, 'h22, 1);
    expectWrite(1, 'h2C7, 3);
    #1;
    check("rec2_valid", recValid, 1);
    check("rec2_idx", recIdx, 2);
    check("rec2_hist", recHist, 5'b00010);
    tick();
    clearLanes();
    drain("drain_rec2");

    // Mispredict on a non-conditional branch: no recovery.
    setLane(0, 32'h0C, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    expectWrite(0, 3, 0);
    #1;
    check("rec_noncond", recValid, 0);
    tick();
    clearLanes();
    drain("drain_noncond");

    // Fill with same-bank pairs so the drain runs at one entry per cycle.
    m       = 0;
    pairs   = 0;
    seenLow = 0;
    for (int cyc = 0; cyc < 12 && seenLow == 0; cyc++) begin
      check("fill_ready", resReady, (m <= DEPTH - LANES) ? 1 : 0);
      pushN = 0;
      if (!resReady) begin
        seenLow = 1;
      end else begin
        setLane(0, 32'((4*pairs + 2) << 2), 5'd0, 2'd1, 1'b1, 1'b0, 1'b1);
        setLane(1, 32'((4*pairs + 4) << 2), 5'd0, 2'd1, 1'b1, 1'b0, 1'b1);
        expectWrite(0, 4*pairs + 2, 2);
        expectWrite(0, 4*pairs + 4, 2);
        pairs++;
        pushN = 2;
      end
      tick();
      clearLanes();
      m = m + pushN - ((m > 0) ? 1 : 0);
    end
    check("fill_saw_ready_low", seenLow, 1);
    check("pairs_before_full", pairs, 6);

    // Reset in the middle of draining.
    tick();
    #2;
    rst = 1'b1;
    setLane(0, 32'h1C, 5'b10110, 2'd0, 1'b1, 1'b1, 1'b1);
    #1;
    check("midrst_phtWE", phtWE, 0);
    check("midrst_recValid", recValid, 0);
    check("midrst_resReady", resReady, 0);
    check("midrst_initBusy", initBusy, 1);
    expQ.delete();
    clearLanes();
    tick();
    check("midrst_held_phtWE", phtWE, 0);
    tick();

    runInit();

    // Queue must come out of the second init empty.
    tick();
    setLane(0, 32'h08, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    expectWrite(0, 2, 0);
    tick();
    clearLanes();
    drain("drain_post_reinit");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
